// File: rtl/alu_hs_if.sv
// Handshake bundle for alu_hs: operation request channel and result channel.
`default_nettype none

interface alu_hs_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_OUT;
  logic             Arith_Flag;
  logic             Logic_Flag;
  logic             CMP_Flag;
  logic             Shift_Flag;
  logic             Carry_Flag;
  logic             Zero_Flag;
  logic             Div0_Flag;

  modport slave (
    input  in_valid, A, B, ALU_FUN, out_ready,
    output in_ready, out_valid, ALU_OUT,
           Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
           Carry_Flag, Zero_Flag, Div0_Flag
  );

  modport master (
    output in_valid, A, B, ALU_FUN, out_ready,
    input  in_ready, out_valid, ALU_OUT,
           Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
           Carry_Flag, Zero_Flag, Div0_Flag
  );
endinterface

`default_nettype wire

// File: rtl/alu_hs.sv
// +--------------------------------------------------------------------------+
// | alu_hs: handshaked WIDTH-bit ALU; ALU_HS_DIV_EN enables iterative divide |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_hs #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_hs_if.slave  bus
);

`ifdef ALU_HS_DIV_EN
  typedef enum logic [0:0] {IDLE = 1'b0, DIV = 1'b1} state_t;
  localparam int CNT_W = $clog2(WIDTH + 1);
`else
  typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

  typedef struct packed {
    logic arith;
    logic logc;
    logic cmp;
    logic shift;
    logic carry;
    logic zero;
    logic div0;
  } flags_t;

  state_t           state_q, state_d;
  logic             live_q;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  flags_t           fl_q, fl_d;

  logic [WIDTH-1:0]   op_res;
  flags_t             op_fl;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic               accept;
  logic               drain;
  logic               single_load;

`ifdef ALU_HS_DIV_EN
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] shifted;
  logic             fits;
  logic             div_start;
`endif

  // live_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready = live_q && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;

  always_comb begin
    sum    = {1'b0, bus.A} + {1'b0, bus.B};
    prod   = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    op_res = '0;
    op_fl  = '0;
`ifdef ALU_HS_DIV_EN
    div_start = 1'b0;
`endif
    case (bus.ALU_FUN)
      4'b0000: begin op_res = sum[WIDTH-1:0]; op_fl.arith = 1'b1; op_fl.carry = sum[WIDTH]; end
      4'b0001: begin op_res = bus.A - bus.B; op_fl.arith = 1'b1; op_fl.carry = (bus.A < bus.B); end
      4'b0010: begin op_res = prod[WIDTH-1:0]; op_fl.arith = 1'b1; op_fl.carry = |prod[2*WIDTH-1:WIDTH]; end
      4'b0011: begin
        op_fl.arith = 1'b1;
`ifdef ALU_HS_DIV_EN
        if (bus.B == '0) begin
          op_res     = '1;
          op_fl.div0 = 1'b1;
        end else begin
          div_start = 1'b1;
        end
`endif
      end
      4'b0100: begin op_res = bus.A & bus.B;    op_fl.logc = 1'b1; end
      4'b0101: begin op_res = bus.A | bus.B;    op_fl.logc = 1'b1; end
      4'b0110: begin op_res = ~(bus.A & bus.B); op_fl.logc = 1'b1; end
      4'b0111: begin op_res = ~(bus.A | bus.B); op_fl.logc = 1'b1; end
      4'b1000: begin op_res = bus.A ^ bus.B;    op_fl.logc = 1'b1; end
      4'b1001: begin op_res = ~(bus.A ^ bus.B); op_fl.logc = 1'b1; end
      4'b1010: begin op_res = (bus.A == bus.B) ? WIDTH'(1) : '0; op_fl.cmp = 1'b1; end
      4'b1011: begin op_res = (bus.A > bus.B)  ? WIDTH'(2) : '0; op_fl.cmp = 1'b1; end
      4'b1100: begin op_res = (bus.A < bus.B)  ? WIDTH'(3) : '0; op_fl.cmp = 1'b1; end
      4'b1101: begin op_res = bus.A >> 1; op_fl.shift = 1'b1; op_fl.carry = bus.A[0]; end
      4'b1110: begin op_res = bus.A << 1; op_fl.shift = 1'b1; op_fl.carry = bus.A[WIDTH-1]; end
      default: begin
        op_res      = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
        op_fl.shift = 1'b1;
        op_fl.carry = bus.A[WIDTH-1];
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    fl_d        = fl_q;
    out_valid_d = out_valid_q && !drain;
    single_load = accept;
`ifdef ALU_HS_DIV_EN
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    single_load = accept && !div_start;
    // Restoring step: shift next dividend bit in, subtract if divisor fits
    shifted     = {rem_q, quo_q[WIDTH-1]};
    fits        = (shifted >= {2'b00, dvs_q});
`endif
    case (state_q)
      IDLE: begin
        if (single_load) begin
          res_d       = op_res;
          fl_d        = op_fl;
          fl_d.zero   = (op_res == '0);
          out_valid_d = 1'b1;
        end
`ifdef ALU_HS_DIV_EN
        if (accept && div_start) begin
          state_d = DIV;
          rem_d   = '0;
          quo_d   = bus.A;
          dvs_d   = bus.B;
          cnt_d   = '0;
        end
`endif
      end
`ifdef ALU_HS_DIV_EN
      DIV: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          res_d       = quo_q;
          fl_d        = '0;
          fl_d.arith  = 1'b1;
          fl_d.zero   = (quo_q == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          rem_d = (WIDTH+1)'(fits ? shifted - {2'b00, dvs_q} : shifted);
          quo_d = {quo_q[WIDTH-2:0], fits};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      fl_q        <= '0;
`ifdef ALU_HS_DIV_EN
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      fl_q        <= fl_d;
`ifdef ALU_HS_DIV_EN
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.ALU_OUT    = res_q;
  assign bus.Arith_Flag = fl_q.arith;
  assign bus.Logic_Flag = fl_q.logc;
  assign bus.CMP_Flag   = fl_q.cmp;
  assign bus.Shift_Flag = fl_q.shift;
  assign bus.Carry_Flag = fl_q.carry;
  assign bus.Zero_Flag  = fl_q.zero;
  assign bus.Div0_Flag  = fl_q.div0;

endmodule

`default_nettype wire

// File: tb/tb_alu_hs.sv
// Scoreboard bench for alu_hs (WIDTH=16): driver queues expected results, monitor checks each transfer.
`default_nettype none

module tb_alu_hs;
  // Flag vector order: {Arith, Logic, CMP, Shift, Carry, Zero, Div0}
  localparam logic [6:0] F_AR = 7'b1000000;
  localparam logic [6:0] F_LG = 7'b0100000;
  localparam logic [6:0] F_CM = 7'b0010000;
  localparam logic [6:0] F_SH = 7'b0001000;
  localparam logic [6:0] F_CY = 7'b0000100;
  localparam logic [6:0] F_ZR = 7'b0000010;
  localparam logic [6:0] F_D0 = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [22:0] exp_q[$];

  alu_hs_if #(.WIDTH(16)) bus ();
  alu_hs #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] fl;
  assign fl = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag,
               bus.Carry_Flag, bus.Zero_Flag, bus.Div0_Flag};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'h0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, "_alu_out"}, 32'(bus.ALU_OUT), 32'h0);
    chk({tag, "_flags"}, 32'(fl), 32'h0);
  endtask

  // Present an operation and hold it until accepted; returns 1ns after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       input logic [15:0] res, input logic [6:0] f);
    bit ok = 0;
    bus.A = a; bus.B = b; bus.ALU_FUN = op; bus.in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (!ok) begin
      chk("accept_timeout", 32'h0, 32'h1);
    end else begin
      exp_q.push_back({res, f});
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every transfer on the result channel is compared against the queue head.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {9'h0, bus.ALU_OUT, fl}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {9'h0, bus.ALU_OUT, fl}, {9'h0, e});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [15:0] la[8], lb[8], lr[8];
  logic [3:0]  lop[8];
  logic [6:0]  lf[8];
  int          t0;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.ALU_FUN = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", 32'(bus.in_ready), 32'h1);

    issue(16'd3, 16'd4, 4'b0000, 16'd7, F_AR);
    chk("add_latency1", 32'(bus.out_valid), 32'h1);
    issue(16'hFFFF, 16'h0001, 4'b0000, 16'h0000, F_AR | F_CY | F_ZR);
    issue(16'd2, 16'd5, 4'b0001, 16'hFFFD, F_AR | F_CY);
    issue(16'h0100, 16'h0100, 4'b0010, 16'h0000, F_AR | F_CY | F_ZR);
    issue(16'd12, 16'd13, 4'b0010, 16'h009C, F_AR);
    issue(16'd5, 16'd3, 4'b1011, 16'd2, F_CM);
    issue(16'd3, 16'd5, 4'b1100, 16'd3, F_CM);
    issue(16'd5, 16'd3, 4'b1100, 16'd0, F_CM | F_ZR);
    issue(16'h0003, 16'h0, 4'b1101, 16'h0001, F_SH | F_CY);
    issue(16'h8001, 16'h0, 4'b1110, 16'h0002, F_SH | F_CY);
    bus.in_valid = 1'b0;

`ifdef ALU_HS_DIV_EN
    issue(16'd5, 16'd0, 4'b0011, 16'hFFFF, F_AR | F_D0);
`else
    issue(16'd5, 16'd0, 4'b0011, 16'h0000, F_AR | F_ZR);
`endif
    bus.in_valid = 1'b0;
    chk("div0_latency1", 32'(bus.out_valid), 32'h1);
    @(posedge clk); #1;

`ifdef ALU_HS_DIV_EN
    issue(16'd1000, 16'd7, 4'b0011, 16'd142, F_AR);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("div_busy_in_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk); #1;
    end
    chk("div_not_early", 32'(bus.out_valid), 32'h0);
    @(posedge clk); #1;
    chk("div_latency17", 32'(bus.out_valid), 32'h1);
    @(posedge clk); #1;
`else
    issue(16'd1000, 16'd7, 4'b0011, 16'h0000, F_AR | F_ZR);
    bus.in_valid = 1'b0;
    chk("div_stub_latency1", 32'(bus.out_valid), 32'h1);
    @(posedge clk); #1;
`endif

    // Reset mid-operation (mid-division when the divider is built in)
`ifdef ALU_HS_DIV_EN
    issue(16'd1000, 16'd7, 4'b0011, 16'd142, F_AR);
`else
    issue(16'd1000, 16'd7, 4'b0011, 16'h0000, F_AR | F_ZR);
`endif
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_abort", 32'(bus.in_ready), 32'h1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_output", 32'(bus.out_valid), 32'h0);

    // Backpressure: result must hold while the consumer stalls
    bus.out_ready = 1'b0;
    issue(16'h8001, 16'h0, 4'b1111, 16'h0003, F_SH | F_CY);
    bus.A = 16'd9; bus.B = 16'd9; bus.ALU_FUN = 4'b1010; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'h1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
      chk("hold_data", {9'h0, bus.ALU_OUT, fl}, {9'h0, 16'h0003, F_SH | F_CY});
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    issue(16'd9, 16'd9, 4'b1010, 16'd1, F_CM);
    bus.in_valid = 1'b0;
    chk("cmp_after_hold_valid", 32'(bus.out_valid), 32'h1);
    @(posedge clk); #1;

    // Throughput: eight logic operations back to back
    la  = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0F0F, 16'h1234};
    lb  = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hF0F0, 16'h4321};
    lop = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0100, 4'b0101};
    lr  = '{16'hF000, 16'hFFF0, 16'h0FFF, 16'h000F, 16'h0FF0, 16'hF00F, 16'h0000, 16'h5335};
    lf  = '{F_LG, F_LG, F_LG, F_LG, F_LG, F_LG, F_LG | F_ZR, F_LG};
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      issue(la[i], lb[i], lop[i], lr[i], lf[i]);
      chk("stream_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.in_valid = 1'b0;
    chk("stream_cycles", 32'(cyc - t0), 32'd8);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_drained", 32'(bus.out_valid), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_hs.md
# alu_hs

Parametrised, handshaked successor to the team's single-cycle 16-bit ALU. It adds the following:
- generic operand width;
- valid/ready flow control on input and output;
- carry, zero and divide-by-zero status;
- a rotate opcode;
- an iterative multi-cycle divider in place of a combinational `/`.

It sits between the datapath register file and the writeback stage, one operation in flight at a time.

## Interface
- `WIDTH`, 16, operand/result width in bits (≥ 4)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block can accept an operation this cycle
- `A`  in  WIDTH  operand A
- `B`  in  WIDTH  operand B
- `ALU_FUN`  in  4  opcode
- `out_valid`  out  1  result/flags valid
- `out_ready`  in  1  consumer takes result
- `ALU_OUT`  out  WIDTH  result
- `Arith_Flag`, `Logic_Flag`, `CMP_Flag`, `Shift_Flag`  out  1 each  operation class of current result
- `Carry_Flag`  out  1  carry/borrow/shifted-out bit
- `Zero_Flag`  out  1  `ALU_OUT == 0`
- `Div0_Flag`  out  1  divide by zero occurred

## Operation
- **Handshake:**
  - Transfer in on `in_valid && in_ready`; operands and opcode are captured at that edge.
  - Transfer out on `out_valid && out_ready`.
  - `in_ready = (state == IDLE) && (!out_valid || out_ready)`, so an accept may coincide with a result drain.
- **Opcodes** (class flag in brackets):
  - 0000 `A+B`, Carry = carry-out [Arith]
  - 0001 `A-B`, Carry = borrow (`A<B`) [Arith]
  - 0010 `A*B`, low WIDTH bits, Carry = 1 if the high half is non-zero [Arith]
  - 0011 `A/B`, quotient; see divider below [Arith]
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR [Logic]
  - 1010 `(A==B) ? 1 : 0` [CMP]
  - 1011 `(A>B) ? 2 : 0` [CMP]
  - 1100 `(A<B) ? 3 : 0` [CMP]
  - 1101 `A>>1`, Carry = A[0] [Shift]
  - 1110 `A<<1`, Carry = A[WIDTH-1] [Shift]
  - 1111 rotate-left 1, Carry = A[WIDTH-1] [Shift]
- All comparisons are unsigned.
- Carry is 0 for Logic and CMP operations.
- `Div0_Flag` is 0 except on a divide with `B == 0`.
- **FSM states:** IDLE, DIV.
  - IDLE → DIV on accept of 0011 with `B != 0`.
  - DIV → IDLE after WIDTH iteration cycles.
  - Every other accept stays in IDLE.
- **Divider:**
  - Restoring, one quotient bit per cycle, MSB first.
  - Registers: remainder (WIDTH+1 bits), quotient (WIDTH bits), counter (`$clog2(WIDTH+1)` bits).
- **Divide by zero:**
  - No iteration.
  - `ALU_OUT` = all ones, `Div0_Flag = 1`, `Arith_Flag = 1`, Carry = 0.
  - Same latency as a single-cycle operation.

## Timing
- **Reset values:** `in_ready = 0` during reset, then 1 in the first cycle after release. `out_valid`, `ALU_OUT`, and all seven flags are 0. State is IDLE.
- **Single-cycle opcodes:**
  - Result and flags are registered at the accept edge.
  - `out_valid = 1` in the next cycle (latency 1).
  - Back-to-back throughput of 1 per cycle while `out_ready = 1`.
- **Divide:**
  - Accept at edge N.
  - `out_valid` rises after edge N+WIDTH+1 (17 cycles for WIDTH=16).
  - `in_ready = 0` throughout DIV.
- **Output hold:** while `out_valid && !out_ready`, `ALU_OUT` and all flags hold stable and `in_ready = 0`.
- **Clearing `out_valid`:** it falls in the cycle after a transfer unless a new accept happened at the same edge.
- **Ignored input:** `in_valid` with `in_ready = 0` is ignored. The source must hold its values until accepted.
- **Reset mid-division:** aborts immediately to IDLE with all outputs at reset values. The partial result is discarded.
- **Zero_Flag** is computed from the final registered result, including divide results.

## Configuration
- **Macro:** `ALU_HS_DIV_EN`.
- **Defined:** the iterative divider, DIV state and counter are compiled in, with behaviour as above.
- **Undefined:**
  - No divider logic and no DIV state.
  - Opcode 0011 completes with latency 1.
  - `ALU_OUT = 0`, `Arith_Flag = 1`, `Div0_Flag = 0`, `Zero_Flag = 1`.

## Test plan
All scenarios use WIDTH=16.
- **Reset:** assert `rst = 0` mid-stream → all outputs 0. After release, `in_ready = 1`. First accept of `A=3, B=4, 0000` → next cycle `ALU_OUT = 7`, Arith = 1, Carry = 0, Zero = 0.
- **Carry/zero:** `A=0xFFFF, B=0x0001, 0000` → `ALU_OUT = 0`, Carry = 1, Zero = 1. `A=2, B=5, 0001` → `0xFFFD`, Carry = 1.
- **Divide** (macro on): `A=1000, B=7, 0011` → `in_ready` low for 16 cycles, then `ALU_OUT = 142` with `out_valid` 17 cycles after accept. Abort variant: `rst = 0` at iteration 8 → outputs 0, IDLE.
- **Divide by zero:** `A=5, B=0, 0011` → 1 cycle later `ALU_OUT = 0xFFFF`, Div0 = 1, Arith = 1.
- **Backpressure:** hold `out_ready = 0` after `0x8001 rotate-left (1111)` → `ALU_OUT = 0x0003`, Carry = 1, Shift = 1, all stable for 5 cycles with `in_ready = 0`. Raise `out_ready` together with a new `1010` (`A = B = 9`) → next cycle `ALU_OUT = 1`, CMP = 1.
- **Throughput:** stream 8 logic operations with `in_valid` and `out_ready` tied high → 8 consecutive `out_valid` cycles, results in order (e.g. `0xF0F0 NAND 0xFF00 = 0x0FFF`).
